// File: rtl/ad9826_serial_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ad9826_serial_responder                                      |
// | Description : Slave-side model of the AD9826 3-wire configuration port.    |
// |               Oversamples SLOAD/SCLK/SDATA on clk and accepts 16-bit       |
// |               write frames into an 8 x 9-bit register file. When the       |
// |               readback feature is compiled in, it also answers read frames |
// |               by driving SDATA. The register file is exported flat.        |
// | Ports       : clk, rst_n (async, active low)                               |
// |               ad_sload, ad_sclk, ad_sdata_in      - serial bus pins        |
// |               ad_sdata_out, ad_sdata_oe           - SDATA pad drive        |
// |               regs_flat[72]                       - reg n at [9n+8:9n]     |
// |               wr_strobe, wr_addr[3], frame_err    - commit/error status    |
// | Config      : define AD9826_RSP_READBACK_EN to build the read path. When   |
// |               undefined, read frames are swallowed and SDATA never driven. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ad9826_serial_responder #(
    parameter int SYNC_STAGES = 2   // synchronizer depth per pin, minimum 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ad_sload,
    input  logic        ad_sclk,
    input  logic        ad_sdata_in,
    output logic        ad_sdata_out,
    output logic        ad_sdata_oe,
    output logic [71:0] regs_flat,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_WRITE  = 2'd2,
        S_READ   = 2'd3
    } state_t;

    localparam logic [4:0] c_HDR_LAST   = 5'd6;   // count before the 7th header bit
    localparam logic [4:0] c_FRAME_BITS = 5'd16;

    // ------------------------------------------------------------------
    // Pin synchronizers and registered edge events
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sload_sync;
    logic [SYNC_STAGES-1:0] r_sdata_sync;
    logic                   r_sclk_prev;
    logic                   r_sload_prev;
    logic                   r_sclk_rise;
    logic                   r_sclk_fall;
    logic                   r_sload_rise;
    logic                   r_sload_fall;
    logic                   r_sdata;

    // SLOAD idles high, so its chain resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync  <= '0;
            r_sload_sync <= '1;
            r_sdata_sync <= '0;
            r_sclk_prev  <= 1'b0;
            r_sload_prev <= 1'b1;
            r_sclk_rise  <= 1'b0;
            r_sclk_fall  <= 1'b0;
            r_sload_rise <= 1'b0;
            r_sload_fall <= 1'b0;
            r_sdata      <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], ad_sclk};
            r_sload_sync <= {r_sload_sync[SYNC_STAGES-2:0], ad_sload};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], ad_sdata_in};
            r_sclk_prev  <= r_sclk_sync[SYNC_STAGES-1];
            r_sload_prev <= r_sload_sync[SYNC_STAGES-1];
            r_sclk_rise  <=  r_sclk_sync[SYNC_STAGES-1]  & ~r_sclk_prev;
            r_sclk_fall  <= ~r_sclk_sync[SYNC_STAGES-1]  &  r_sclk_prev;
            r_sload_rise <=  r_sload_sync[SYNC_STAGES-1] & ~r_sload_prev;
            r_sload_fall <= ~r_sload_sync[SYNC_STAGES-1] &  r_sload_prev;
            // Delayed alongside the event registers so data lines up with its SCLK edge.
            r_sdata      <= r_sdata_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and register file
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [4:0]  r_bit_cnt;
    logic [8:0]  r_shift;
    logic [2:0]  r_addr;
    logic [8:0]  r_regs [8];
    logic [8:0]  w_shift_next;

    // After the 7th header bit: [6] = R/W, [5:3] = address.
    assign w_shift_next = {r_shift[7:0], r_sdata};

`ifdef AD9826_RSP_READBACK_EN
    logic       r_oe;
    logic       r_out;
    logic [3:0] w_rd_idx;

    // bit_cnt 7 presents data bit 8, bit_cnt 15 presents data bit 0.
    assign w_rd_idx     = 4'(5'd15 - r_bit_cnt);
    assign ad_sdata_oe  = r_oe;
    assign ad_sdata_out = r_out;
`else
    assign ad_sdata_oe  = 1'b0;
    assign ad_sdata_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
`ifdef AD9826_RSP_READBACK_EN
            r_oe      <= 1'b0;
            r_out     <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            if (r_sload_fall) begin
                // Starts a frame from any state; an open frame is silently dropped.
                r_state   <= S_HEADER;
                r_bit_cnt <= '0;
                r_shift   <= '0;
`ifdef AD9826_RSP_READBACK_EN
                r_oe      <= 1'b0;
`endif
            end else if (r_sload_rise) begin
                r_state <= S_IDLE;
`ifdef AD9826_RSP_READBACK_EN
                r_oe    <= 1'b0;
`endif
                if (r_state == S_HEADER) begin
                    frame_err <= 1'b1;
                end else if (r_state == S_WRITE) begin
                    if (r_bit_cnt == c_FRAME_BITS) begin
                        r_regs[r_addr] <= r_shift;
                        wr_addr        <= r_addr;
                        wr_strobe      <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_HEADER: begin
                        if (r_sclk_rise) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == c_HDR_LAST) begin
                                r_addr <= w_shift_next[5:3];
                                if (w_shift_next[6]) begin
`ifdef AD9826_RSP_READBACK_EN
                                    r_state <= S_READ;
`else
                                    // Read frames are swallowed: remaining edges are ignored in IDLE.
                                    r_state <= S_IDLE;
`endif
                                end else begin
                                    r_state <= S_WRITE;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (r_sclk_rise) begin
                            if (r_bit_cnt == c_FRAME_BITS) begin
                                frame_err <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
`ifdef AD9826_RSP_READBACK_EN
                    S_READ: begin
                        if (r_sclk_rise) begin
                            if (r_bit_cnt == c_FRAME_BITS) begin
                                frame_err <= 1'b1;
                                r_oe      <= 1'b0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else if (r_sclk_fall) begin
                            if (r_bit_cnt == c_FRAME_BITS) begin
                                r_oe <= 1'b0;
                            end else begin
                                r_oe  <= 1'b1;
                                r_out <= r_regs[r_addr][w_rd_idx];
                            end
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign regs_flat[9*g +: 9] = r_regs[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_ad9826_serial_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ad9826_serial_responder                                   |
// | Description : Directed bench for ad9826_serial_responder. An initiator     |
// |               task drives frames; an event-scheduled model predicts the    |
// |               outputs and one process compares them every cycle.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ad9826_serial_responder;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;   // pin edge to output change, in clk cycles
    localparam int H    = 8;          // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ad_sload;
    logic        ad_sclk;
    logic        line;
    logic        ad_sdata_out;
    logic        ad_sdata_oe;
    logic [71:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic        frame_err;

    logic        drv_en;
    logic        drv_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_strobe = 0;
    int n_err    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SDATA pad with a weak pull-down when nobody drives it.
    always_comb begin
        line = 1'b0;
        if (ad_sdata_oe)  line = ad_sdata_out;
        else if (drv_en)  line = drv_val;
    end

    ad9826_serial_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ad_sload     (ad_sload),
        .ad_sclk      (ad_sclk),
        .ad_sdata_in  (line),
        .ad_sdata_out (ad_sdata_out),
        .ad_sdata_oe  (ad_sdata_oe),
        .regs_flat    (regs_flat),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .frame_err    (frame_err)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: expected output changes are scheduled at absolute cycles
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int kind;   // 0 oe, 1 out, 2 commit (a=addr,b=data), 3 frame error
        int a;
        int b;
    } ev_t;

    ev_t        q[$];
    logic [8:0] exp_regs [8];
    logic       exp_oe;
    logic       exp_out;
    logic [2:0] exp_wr_addr;
    logic       exp_strobe;
    logic       exp_err;

    function automatic logic [71:0] flat_model();
        logic [71:0] f;
        for (int i = 0; i < 8; i++) f[9*i +: 9] = exp_regs[i];
        return f;
    endfunction

    task automatic push(input int c, input int k, input int a, input int b);
        ev_t e;
        e.cyc = c; e.kind = k; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_strobe = 1'b0;
        exp_err    = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) exp_regs[i] = '0;
            exp_oe      = 1'b0;
            exp_out     = 1'b0;
            exp_wr_addr = '0;
            q.delete();
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    case (q[i].kind)
                        0: exp_oe  = q[i].a[0];
                        1: exp_out = q[i].a[0];
                        2: begin
                            exp_regs[q[i].a] = q[i].b[8:0];
                            exp_wr_addr      = q[i].a[2:0];
                            exp_strobe       = 1'b1;
                        end
                        default: exp_err = 1'b1;
                    endcase
                    q.delete(i);
                end
            end
        end
        chk("sdata_oe",  ad_sdata_oe, exp_oe);
        chk("wr_strobe", wr_strobe,   exp_strobe);
        chk("frame_err", frame_err,   exp_err);
        chk("wr_addr",   wr_addr,     exp_wr_addr);
        chk("regs_flat", regs_flat,   flat_model());
        if (exp_oe) chk("sdata_out", ad_sdata_out, exp_out);
        if (wr_strobe) n_strobe++;
        if (frame_err) n_err++;
    end

    // ------------------------------------------------------------------
    // Initiator
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] w, input int nbits, input bit is_read,
                         input bit end_frame, output logic [8:0] cap);
        int addr;
        int cnt;
        addr = int'(w[14:12]);
        cap  = '0;
        ad_sload = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            // Data changes together with the SCLK falling edge.
            if (is_read && i >= 7) begin
                drv_en = 1'b0;
            end else begin
                drv_en  = 1'b1;
                drv_val = (i < 16) ? w[15-i] : 1'b0;
            end
            tick(H);
            if (is_read && i >= 7 && i < 16) cap = {cap[7:0], line};
            ad_sclk = 1'b1;
            if (!is_read && i == 16) push(cyc + LAT, 3, 0, 0);
            tick(H);
            ad_sclk = 1'b0;
            cnt = i + 1;
`ifdef AD9826_RSP_READBACK_EN
            if (is_read && cnt >= 7) begin
                if (cnt == 7)  push(cyc + LAT, 0, 1, 0);
                if (cnt <= 15) push(cyc + LAT, 1, int'(exp_regs[addr][15-cnt]), 0);
                if (cnt == 16) push(cyc + LAT, 0, 0, 0);
            end
`endif
        end
        drv_en = 1'b0;
        if (end_frame) begin
            tick(H);
            ad_sload = 1'b1;
            if (is_read) begin
`ifdef AD9826_RSP_READBACK_EN
                push(cyc + LAT, 0, 0, 0);
`endif
            end else if (nbits == 16) begin
                push(cyc + LAT, 2, addr, int'(w[8:0]));
            end else if (nbits < 16) begin
                push(cyc + LAT, 3, 0, 0);
            end
            tick(H + LAT + 2);
        end
    endtask

    logic [8:0] cap;
    logic [8:0] exp_cap;
    logic       exp_mid_oe;

    initial begin
`ifdef AD9826_RSP_READBACK_EN
        exp_cap    = 9'h1A5;
        exp_mid_oe = 1'b1;
`else
        exp_cap    = 9'h000;
        exp_mid_oe = 1'b0;
`endif
        rst_n    = 1'b0;
        ad_sload = 1'b1;
        ad_sclk  = 1'b0;
        drv_en   = 1'b0;
        drv_val  = 1'b0;
        tick(5);
        chk("reset regs", regs_flat, 72'h0);
        chk("reset oe",   ad_sdata_oe, 1'b0);
        rst_n = 1'b1;
        tick(10);

        // Write 0x158 to reg0
        frame(16'h0158, 16, 1'b0, 1'b1, cap);
        chk("write reg0",    regs_flat[8:0], 9'h158);
        chk("write others",  regs_flat[71:9], 63'h0);
        chk("write wr_addr", wr_addr, 3'd0);
        chk("write strobes", n_strobe, 1);

        // Preload reg5, then read it back
        frame(16'h51A5, 16, 1'b0, 1'b1, cap);
        frame(16'hD000, 16, 1'b1, 1'b1, cap);
        chk("read capture", cap, exp_cap);
        chk("read reg5",    regs_flat[53:45], 9'h1A5);
        chk("read oe end",  ad_sdata_oe, 1'b0);
        chk("read no err",  n_err, 0);

        // Short write: 12 bits only
        frame(16'h2FFF, 12, 1'b0, 1'b1, cap);
        chk("short reg2",    regs_flat[26:18], 9'h000);
        chk("short errs",    n_err, 1);
        chk("short strobes", n_strobe, 2);

        // Overlong write: 17 rising edges
        frame(16'h3001, 17, 1'b0, 1'b1, cap);
        chk("long reg3",    regs_flat[35:27], 9'h000);
        chk("long errs",    n_err, 2);
        chk("long strobes", n_strobe, 2);

        // Reset during a read frame
        frame(16'hD000, 10, 1'b1, 1'b0, cap);
        tick(LAT);
        chk("mid-read oe", ad_sdata_oe, exp_mid_oe);
        rst_n    = 1'b0;
        ad_sload = 1'b1;
        ad_sclk  = 1'b0;
        #2;
        chk("rst oe",   ad_sdata_oe, 1'b0);
        chk("rst regs", regs_flat, 72'h0);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        frame(16'h7003, 16, 1'b0, 1'b1, cap);
        chk("post-rst reg7",    regs_flat[71:63], 9'h003);
        chk("post-rst wr_addr", wr_addr, 3'd7);
        chk("post-rst low",     regs_flat[62:0], 63'h0);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
